// File: rtl/eoc_monitor.sv
// End-of-computation monitor: arms on start, collects per-channel completion reports,
// records the first failing exit code, and flags completion or timeout.
// Optional heartbeat output is compiled in with `define EOC_MONITOR_HEARTBEAT_EN.
module eoc_monitor #(
  parameter int NumChan  = 2,
  parameter int CntWidth = 32,
  parameter int HbPeriod = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NumChan-1:0]    chan_en_i,
  input  logic [CntWidth-1:0]   timeout_i,
  input  logic [NumChan-1:0]    eoc_valid_i,
  input  logic [NumChan*32-1:0] eoc_code_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [NumChan-1:0]    chan_done_o,
  output logic [30:0]           exit_code_o,
  output logic [CntWidth-1:0]   cycles_o,
  output logic                  heartbeat_o
);

  if (NumChan < 1 || NumChan > 32 || HbPeriod < 1) begin : g_bad_param
    $error("eoc_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e               state_q, state_d;
  logic [NumChan-1:0]   mask_q, mask_d;
  logic [CntWidth-1:0]  timeout_q, timeout_d;
  logic [NumChan-1:0]   chan_done_q, chan_done_d;
  logic [CntWidth-1:0]  cycles_q, cycles_d;
  logic [30:0]          exit_code_q, exit_code_d;
  logic                 fail_q, fail_d;
  logic                 pass_q, pass_d;

  logic [NumChan-1:0]   accept;
  logic                 all_done;
  logic                 captured;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    timeout_d   = timeout_q;
    chan_done_d = chan_done_q;
    cycles_d    = cycles_q;
    exit_code_d = exit_code_q;
    fail_d      = fail_q;
    pass_d      = pass_q;
    accept      = '0;
    all_done    = 1'b0;
    captured    = 1'b0;

    for (int k = 0; k < NumChan; k++) begin
      accept[k] = (state_q == ST_RUN) && mask_q[k] && !chan_done_q[k]
                  && eoc_valid_i[k] && eoc_code_i[32*k];
    end

    // Only the lowest-index nonzero code can fill the empty first-fail slot.
    for (int k = 0; k < NumChan; k++) begin
      if (accept[k] && !fail_q && !captured && (eoc_code_i[32*k+1 +: 31] != 31'd0)) begin
        exit_code_d = eoc_code_i[32*k+1 +: 31];
        fail_d      = 1'b1;
        captured    = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          mask_d      = chan_en_i;
          timeout_d   = timeout_i;
          chan_done_d = '0;
          cycles_d    = '0;
          exit_code_d = '0;
          fail_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + CntWidth'(1);
        chan_done_d = chan_done_q | accept;
        all_done    = &(chan_done_d | ~mask_q);
        // Completion is checked first so it wins over a coincident timeout.
        if (all_done) begin
          state_d = ST_DONE;
          pass_d  = !fail_d;
        end else if ((timeout_q != '0) && (cycles_q == timeout_q - CntWidth'(1))) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      state_d     = ST_IDLE;
      mask_d      = '0;
      timeout_d   = '0;
      chan_done_d = '0;
      cycles_d    = '0;
      exit_code_d = '0;
      fail_d      = 1'b0;
      pass_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      timeout_q   <= '0;
      chan_done_q <= '0;
      cycles_q    <= '0;
      exit_code_q <= '0;
      fail_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      timeout_q   <= timeout_d;
      chan_done_q <= chan_done_d;
      cycles_q    <= cycles_d;
      exit_code_q <= exit_code_d;
      fail_q      <= fail_d;
      pass_q      <= pass_d;
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign timeout_o   = (state_q == ST_TIMEOUT);
  assign pass_o      = pass_q;
  assign chan_done_o = chan_done_q;
  assign exit_code_o = exit_code_q;
  assign cycles_o    = cycles_q;

`ifdef EOC_MONITOR_HEARTBEAT_EN
  localparam int HbW = (HbPeriod > 1) ? $clog2(HbPeriod) : 1;

  logic [HbW-1:0] hb_cnt_q, hb_cnt_d;
  logic           hb_q, hb_d;

  // Counter phase is tied to start so pulses land every HbPeriod run cycles.
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    hb_d     = 1'b0;
    if (clear_i) begin
      hb_cnt_d = '0;
    end else if (state_q == ST_IDLE && start_i) begin
      hb_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (hb_cnt_q == HbW'(HbPeriod - 1)) begin
        hb_cnt_d = '0;
        hb_d     = (state_d == ST_RUN);
      end else begin
        hb_cnt_d = hb_cnt_q + HbW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign heartbeat_o = hb_q;
`else
  assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_eoc_monitor.sv
// Directed self-checking bench for eoc_monitor (NumChan=2, HbPeriod=10).
module tb_eoc_monitor;

  localparam int NumChan  = 2;
  localparam int CntWidth = 32;
  localparam int HbPeriod = 10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  clear = 1'b0;
  logic [NumChan-1:0]    chanEn = '0;
  logic [CntWidth-1:0]   timeoutVal = '0;
  logic [NumChan-1:0]    eocValid = '0;
  logic [NumChan*32-1:0] eocCode = '0;
  logic                  busy, done, pass, tmo, heartbeat;
  logic [NumChan-1:0]    chanDone;
  logic [30:0]           exitCode;
  logic [CntWidth-1:0]   cycles;

  int assertCount = 0;
  int failCount   = 0;
  logic hbExp;

  eoc_monitor #(
    .NumChan (NumChan),
    .CntWidth(CntWidth),
    .HbPeriod(HbPeriod)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .clear_i    (clear),
    .chan_en_i  (chanEn),
    .timeout_i  (timeoutVal),
    .eoc_valid_i(eocValid),
    .eoc_code_i (eocCode),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .timeout_o  (tmo),
    .chan_done_o(chanDone),
    .exit_code_o(exitCode),
    .cycles_o   (cycles),
    .heartbeat_o(heartbeat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NumChan-1:0] valid, input logic [NumChan*32-1:0] code);
    eocValid = valid;
    eocCode  = code;
    tick();
    eocValid = '0;
    eocCode  = '0;
  endtask

  task automatic startRun(input logic [NumChan-1:0] mask, input logic [CntWidth-1:0] tmoCycles);
    chanEn     = mask;
    timeoutVal = tmoCycles;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearAll();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_tmo"}, 64'(tmo), 64'd0);
    checkOutput({tag, "_chdone"}, 64'(chanDone), 64'd0);
    checkOutput({tag, "_exit"}, 64'(exitCode), 64'd0);
    checkOutput({tag, "_cycles"}, 64'(cycles), 64'd0);
    checkOutput({tag, "_hb"}, 64'(heartbeat), 64'd0);
  endtask

  initial begin
    ticks(2);
    checkIdle("reset");
    rst = 1'b0;
    tick();

    // Two channels pass: ch0 at cycle 5, ch1 at cycle 9, done at cycle 10.
    startRun(2'b11, 32'd0);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_cyc0", 64'(cycles), 64'd0);
    ticks(5);
    applyStimulus(2'b01, {32'h0, 32'h1});
    checkOutput("t1_chdone0", 64'(chanDone), 64'b01);
    checkOutput("t1_busy2", 64'(busy), 64'd1);
    ticks(3);
    applyStimulus(2'b10, {32'h1, 32'h0});
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_cyc10", 64'(cycles), 64'd10);
    checkOutput("t1_pass", 64'(pass), 64'd1);
    checkOutput("t1_exit", 64'(exitCode), 64'd0);
    checkOutput("t1_chdone", 64'(chanDone), 64'b11);
    checkOutput("t1_busyoff", 64'(busy), 64'd0);
    ticks(3);
    checkOutput("t1_hold_done", 64'(done), 64'd1);
    checkOutput("t1_hold_cyc", 64'(cycles), 64'd10);
    clearAll();
    checkIdle("t1_clear");

    // Same-cycle failing reports: lowest index code wins; start mid-run ignored.
    startRun(2'b11, 32'd0);
    tick();
    startRun(2'b00, 32'd5);
    checkOutput("t2_restart_cyc", 64'(cycles), 64'd2);
    checkOutput("t2_restart_busy", 64'(busy), 64'd1);
    applyStimulus(2'b11, {32'h7, 32'h5});
    checkOutput("t2_done", 64'(done), 64'd1);
    checkOutput("t2_exit", 64'(exitCode), 64'd2);
    checkOutput("t2_pass", 64'(pass), 64'd0);
    checkOutput("t2_tmo", 64'(tmo), 64'd0);
    checkOutput("t2_cyc", 64'(cycles), 64'd3);
    clearAll();

    // Timeout after 100 run cycles with no report.
    startRun(2'b01, 32'd100);
    ticks(99);
    checkOutput("t3_cyc99_busy", 64'(busy), 64'd1);
    checkOutput("t3_cyc99_tmo", 64'(tmo), 64'd0);
    tick();
    checkOutput("t3_tmo", 64'(tmo), 64'd1);
    checkOutput("t3_done", 64'(done), 64'd0);
    checkOutput("t3_busy", 64'(busy), 64'd0);
    checkOutput("t3_cyc", 64'(cycles), 64'd100);
    checkOutput("t3_pass", 64'(pass), 64'd0);
    ticks(2);
    checkOutput("t3_hold_tmo", 64'(tmo), 64'd1);
    clearAll();

    // Report on the last cycle before timeout: completion wins.
    startRun(2'b01, 32'd100);
    ticks(99);
    applyStimulus(2'b01, {32'h0, 32'h1});
    checkOutput("t3b_done", 64'(done), 64'd1);
    checkOutput("t3b_tmo", 64'(tmo), 64'd0);
    checkOutput("t3b_pass", 64'(pass), 64'd1);
    clearAll();

    // Ignored reports: disabled channel, bit0 clear, repeat after acceptance.
    startRun(2'b01, 32'd0);
    ticks(2);
    applyStimulus(2'b10, {32'h7, 32'h0});
    checkOutput("t4_dis_chdone", 64'(chanDone), 64'd0);
    checkOutput("t4_dis_exit", 64'(exitCode), 64'd0);
    applyStimulus(2'b01, {32'h0, 32'h6});
    checkOutput("t4_bit0_chdone", 64'(chanDone), 64'd0);
    checkOutput("t4_bit0_busy", 64'(busy), 64'd1);
    applyStimulus(2'b01, {32'h0, 32'hB});
    checkOutput("t4_done", 64'(done), 64'd1);
    checkOutput("t4_exit", 64'(exitCode), 64'd5);
    checkOutput("t4_pass", 64'(pass), 64'd0);
    applyStimulus(2'b01, {32'h0, 32'hF});
    checkOutput("t4_exit_kept", 64'(exitCode), 64'd5);
    clearAll();

    // Empty mask completes the cycle after start with pass.
    startRun(2'b00, 32'd0);
    checkOutput("t6_busy", 64'(busy), 64'd1);
    tick();
    checkOutput("t6_done", 64'(done), 64'd1);
    checkOutput("t6_pass", 64'(pass), 64'd1);
    checkOutput("t6_exit", 64'(exitCode), 64'd0);
    checkOutput("t6_cyc", 64'(cycles), 64'd1);
    clearAll();

    // Heartbeat cadence during a long run.
    startRun(2'b01, 32'd0);
    for (int i = 1; i <= 35; i++) begin
      tick();
`ifdef EOC_MONITOR_HEARTBEAT_EN
      hbExp = (i % 10 == 0);
`else
      hbExp = 1'b0;
`endif
      checkOutput($sformatf("hb_c%0d", i), 64'(heartbeat), 64'(hbExp));
    end
    clearAll();

    // Async reset mid-run, then simultaneous clear and start.
    startRun(2'b11, 32'd0);
    ticks(3);
    applyStimulus(2'b01, {32'h0, 32'h3});
    rst = 1'b1;
    #1;
    checkIdle("t5_async");
    tick();
    rst = 1'b0;
    chanEn = 2'b11;
    clear  = 1'b1;
    start  = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    checkIdle("t5_clrstart");
    tick();
    checkIdle("t5_after");
    startRun(2'b11, 32'd0);
    checkOutput("t5_rearm", 64'(busy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/eoc_monitor.md
EOC_MONITOR -- requirements
Module: eoc_monitor

Interface
REQ-001 SHALL have parameter NumChan, default 2, meaning number of monitored end-of-computation channels (1..32).
REQ-002 SHALL have parameter CntWidth, default 32, meaning width of the cycle counter and the timeout value.
REQ-003 SHALL have parameter HbPeriod, default 1000, meaning heartbeat period in cycles (>=1).
REQ-004 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset); one clock, reset asynchronous and active-high.
REQ-005 SHALL have start_i in 1, a pulse that arms monitoring.
REQ-006 SHALL have clear_i in 1, a pulse that returns the block to IDLE.
REQ-007 SHALL have chan_en_i in NumChan, the channel enable mask, sampled on start.
REQ-008 SHALL have timeout_i in CntWidth, the timeout in cycles (0 = disabled), sampled on start.
REQ-009 SHALL have eoc_valid_i in NumChan, a per-channel single-cycle report strobe.
REQ-010 SHALL have eoc_code_i in NumChan*32, the per-channel 32-bit report word; channel k occupies bits [32k+31:32k].
REQ-011 SHALL have outputs busy_o 1, done_o 1, pass_o 1, timeout_o 1, chan_done_o NumChan, exit_code_o 31, cycles_o CntWidth and heartbeat_o 1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE and TIMEOUT.
REQ-013 SHALL go IDLE->RUN on start_i, registering chan_en_i and timeout_i, clearing chan_done_o and cycles_o, and setting the first-fail slot empty.
REQ-014 SHALL ignore start_i when not in IDLE.
REQ-015 SHALL, in RUN, increment cycles_o by 1 per cycle, saturating at all-ones.
REQ-016 SHALL accept a report on channel k only when in RUN, channel k is enabled, chan_done_o[k]=0 and eoc_valid_i[k]=1 with bit 0 of the word set; all other reports are ignored.
REQ-017 SHALL, on an accepted report, set chan_done_o[k] the next cycle and take code[k] = word[31:1].
REQ-018 SHALL capture into exit_code_o the code of the first accepted nonzero report; lowest index wins on same-cycle reports, and later nonzero codes are not captured.
REQ-019 SHALL go RUN->DONE the cycle after every enabled channel is done, with pass_o = 1 iff no nonzero code was accepted.
REQ-020 SHALL go RUN->DONE on the cycle after start when the registered mask is all zero, with pass_o = 1 and exit_code_o = 0.
REQ-021 SHALL go RUN->TIMEOUT when timeout is nonzero and cycles_o reaches timeout-1 while not all enabled channels are done.
REQ-022 SHALL give completion priority when completion and timeout occur in the same cycle (state DONE).
REQ-023 SHALL hold DONE and TIMEOUT, with outputs stable, until clear_i.
REQ-024 SHALL go from any state to IDLE on clear_i, clearing all status outputs; clear_i wins over a simultaneous start_i.
REQ-025 SHALL drive busy_o = (state==RUN), done_o = (state==DONE) and timeout_o = (state==TIMEOUT), all registered.

Reset
REQ-026 SHALL, on rst_i, asynchronously enter IDLE with all outputs 0 and all counters and registered mask/timeout 0.
REQ-027 SHALL, on reset mid-RUN, abandon all captured state, after which only a new start_i re-arms.

Configuration
REQ-028 SHALL compile the heartbeat in when EOC_MONITOR_HEARTBEAT_EN is defined: heartbeat_o pulses high one cycle every HbPeriod cycles in RUN, and its counter restarts on start_i.
REQ-029 SHALL, when EOC_MONITOR_HEARTBEAT_EN is undefined, tie heartbeat_o to 0 and include no heartbeat counter logic.

Verification
REQ-030 SHALL cover: NumChan=2, mask=2'b11, timeout=0; ch0 word 0x1 at cycle 5, ch1 word 0x1 at cycle 9 -> done_o=1 at cycle 10, pass_o=1, exit_code_o=0.
REQ-031 SHALL cover: mask=2'b11; ch1 word 0x7 (code 3) and ch0 word 0x5 (code 2) in the same cycle -> exit_code_o=2, pass_o=0, done_o next cycle.
REQ-032 SHALL cover: mask=2'b01, timeout=100, no reports -> timeout_o=1 at run cycle 100, done_o=0; the final ch0 report on cycle 99 yields done_o, not timeout_o.
REQ-033 SHALL cover: mask=2'b01; reports on disabled ch1, reports with bit0=0, and a second ch0 report with a nonzero code -> all ignored after the first; exit_code_o unchanged.
REQ-034 SHALL cover: rst_i asserted mid-RUN, then clear_i and start_i pulsed together -> IDLE, all outputs 0, and start_i ignored.
REQ-035 SHALL cover: with EOC_MONITOR_HEARTBEAT_EN and HbPeriod=10 -> heartbeat_o pulses at run cycles 10, 20, 30; without the macro heartbeat_o stays 0.
